imem_uart_loader: RTL and testbench

//  Writer side of the instruction-memory interface: receives a program over a UART
//  8N1 serial line, assembles 32-bit instruction words and writes them into the

---
 rtl/imem_uart_loader_if.sv | 10 +
 rtl/imem_uart_loader.sv | 185 ++++++++++++++++++
 tb/tb_imem_uart_loader.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_uart_loader_if.sv
// Instruction-memory write port shared by the UART loader (master) and the
// instruction memory (slave).
interface imem_uart_loader_if;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    modport master (output wr_en, output wr_addr, output wr_data);
    modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/imem_uart_loader.sv
// UART 8N1 program loader: receives a 16-bit word count followed by big-endian
// 32-bit words, writes them to instruction memory and then releases the CPU.
module imem_uart_loader #(
    parameter int          CLKS_PER_BIT = 868,
    parameter int          DEPTH        = 128,
    parameter logic [31:0] BASE_ADDR    = 32'h0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rx,
    imem_uart_loader_if.master         mem,
    output logic                       cpu_hold,
    output logic                       done,
    output logic                       frame_err,
    output logic                       overflow,
    output logic [15:0]                word_count
);

    localparam int              CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0]      DEPTH_W   = 16'(DEPTH);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {LD_CNT_HI, LD_CNT_LO, LD_DATA, LD_DONE} ld_state_t;

    rx_state_t        rx_state;
    ld_state_t        ld_state;
    logic             rx_meta, rx_sync, rx_prev;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       rx_shift;
    logic             byte_valid;
    logic [7:0]       byte_data;

    logic [15:0]      n_words;
    logic [15:0]      words_rcvd;
    logic [1:0]       byte_pos;
    logic [31:0]      word_buf;
    logic             wr_pending;
    logic             wr_en_q;
    logic [31:0]      wr_addr_q;
    logic [31:0]      wr_data_q;
    logic [15:0]      n_next;

    assign mem.wr_en   = wr_en_q;
    assign mem.wr_addr = wr_addr_q;
    assign mem.wr_data = wr_data_q;
    assign n_next      = {n_words[15:8], byte_data};

    // rx_prev is a third stage used only to see the synced falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state   <= RX_IDLE;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            rx_shift   <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    clk_cnt <= '0;
                    bit_idx <= '0;
                    if (rx_prev && !rx_sync)
                        rx_state <= RX_START;
                end
                RX_START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt  <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (clk_cnt == FULL_LAST) begin
                        clk_cnt  <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
                            rx_state <= RX_STOP;
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (clk_cnt == FULL_LAST) begin
                        clk_cnt  <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_sync) begin
                            byte_valid <= 1'b1;
                            byte_data  <= rx_shift;
                        end else if (ld_state != LD_DONE) begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // A completed word raises wr_pending; the following cycle retires it,
    // which is also where the load finishes, one cycle after the last strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_state   <= LD_CNT_HI;
            n_words    <= '0;
            words_rcvd <= '0;
            byte_pos   <= '0;
            word_buf   <= '0;
            wr_pending <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= BASE_ADDR;
            wr_data_q  <= '0;
            word_count <= '0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            if (wr_pending) begin
                wr_pending <= 1'b0;
                words_rcvd <= words_rcvd + 16'd1;
                if (words_rcvd < DEPTH_W) begin
                    word_count <= word_count + 16'd1;
                    if (word_count + 16'd1 < DEPTH_W)
                        wr_addr_q <= wr_addr_q + 32'd4;
                end
                if (words_rcvd + 16'd1 == n_words) begin
                    ld_state <= LD_DONE;
                    cpu_hold <= 1'b0;
                    done     <= 1'b1;
                end
            end else if (byte_valid) begin
                case (ld_state)
                    LD_CNT_HI: begin
                        n_words[15:8] <= byte_data;
                        ld_state      <= LD_CNT_LO;
                    end
                    LD_CNT_LO: begin
                        n_words[7:0] <= byte_data;
                        if (n_next > DEPTH_W)
                            overflow <= 1'b1;
                        if (n_next == 16'd0) begin
                            ld_state <= LD_DONE;
                            cpu_hold <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            ld_state <= LD_DATA;
                        end
                    end
                    LD_DATA: begin
                        word_buf <= {word_buf[23:0], byte_data};
                        byte_pos <= byte_pos + 2'd1;
                        if (byte_pos == 2'd3) begin
                            wr_pending <= 1'b1;
                            wr_data_q  <= {word_buf[23:0], byte_data};
                            wr_en_q    <= (words_rcvd < DEPTH_W);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader: table of complete loads plus hand-written
// sequences for Done timing, glitch rejection and mid-load reset.
module tb_imem_uart_loader;

    localparam int CPB   = 16;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic        cpu_hold, done, frame_err, overflow;
    logic [15:0] word_count;

    imem_uart_loader_if mem ();

    imem_uart_loader #(
        .CLKS_PER_BIT(CPB),
        .DEPTH       (DEPTH),
        .BASE_ADDR   (32'h0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .mem       (mem),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .frame_err (frame_err),
        .overflow  (overflow),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           nbytes;
        logic [111:0] bytes;
        logic [13:0]  bad;
        int           nwr;
        logic [63:0]  addrs;
        logic [63:0]  datas;
        logic [15:0]  wc;
        logic [31:0]  final_addr;
        logic         dn;
        logic         ovf;
        logic         ferr;
        logic         lag;
    } vec_t;

    vec_t        vecs [4];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          base;
    int          last_wr_cyc = 0;
    int          hold_fall_cyc = 0;
    int          b2b = 0;
    logic        prev_wr = 1'b0;
    logic        prev_hold = 1'b1;
    logic [31:0] max_addr = 32'h0;
    logic [31:0] log_addr [$];
    logic [31:0] log_data [$];
    logic        done_early, done_late;
    logic [9:0]  frame;

    always @(posedge clk) cyc <= cyc + 1;

    // Write-port monitor: logs every strobe and tracks timing properties.
    always @(negedge clk) begin
        if (mem.wr_en === 1'b1) begin
            log_addr.push_back(mem.wr_addr);
            log_data.push_back(mem.wr_data);
            last_wr_cyc = cyc;
            if (prev_wr) b2b++;
        end
        if (prev_hold && cpu_hold === 1'b0) hold_fall_cyc = cyc;
        if (mem.wr_addr > max_addr) max_addr = mem.wr_addr;
        prev_wr   = (mem.wr_en === 1'b1);
        prev_hold = (cpu_hold !== 1'b0);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%h expected 0x%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            rx = data[b];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic doReset();
        rx  = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        rx  = 1'b1;

        vecs[0] = '{nbytes: 10, bytes: {80'h00_02_20_08_00_05_01_09_50_20, 32'h0},
                    bad: 14'h0, nwr: 2, addrs: {32'h0, 32'h4},
                    datas: {32'h20080005, 32'h01095020}, wc: 16'd2, final_addr: 32'h4,
                    dn: 1'b1, ovf: 1'b0, ferr: 1'b0, lag: 1'b1};
        vecs[1] = '{nbytes: 14, bytes: 112'h00_03_11_22_33_44_55_66_77_88_99_AA_BB_CC,
                    bad: 14'h0, nwr: 2, addrs: {32'h0, 32'h4},
                    datas: {32'h11223344, 32'h55667788}, wc: 16'd2, final_addr: 32'h4,
                    dn: 1'b1, ovf: 1'b1, ferr: 1'b0, lag: 1'b0};
        vecs[2] = '{nbytes: 7, bytes: {56'h00_01_DE_55_AD_BE_EF, 56'h0},
                    bad: 14'h0008, nwr: 1, addrs: {32'h0, 32'h0},
                    datas: {32'hDEADBEEF, 32'h0}, wc: 16'd1, final_addr: 32'h4,
                    dn: 1'b1, ovf: 1'b0, ferr: 1'b1, lag: 1'b1};
        vecs[3] = '{nbytes: 6, bytes: {48'h00_02_CA_FE_BA_BE, 64'h0},
                    bad: 14'h0, nwr: 1, addrs: {32'h0, 32'h0},
                    datas: {32'hCAFEBABE, 32'h0}, wc: 16'd1, final_addr: 32'h4,
                    dn: 1'b0, ovf: 1'b0, ferr: 1'b0, lag: 1'b0};

        doReset();
        checkOutput("rst_wr_en",     32'(mem.wr_en),   32'd0);
        checkOutput("rst_wr_addr",   mem.wr_addr,      32'h0);
        checkOutput("rst_wr_data",   mem.wr_data,      32'h0);
        checkOutput("rst_cpu_hold",  32'(cpu_hold),    32'd1);
        checkOutput("rst_done",      32'(done),        32'd0);
        checkOutput("rst_frame_err", 32'(frame_err),   32'd0);
        checkOutput("rst_overflow",  32'(overflow),    32'd0);
        checkOutput("rst_word_count", 32'(word_count), 32'd0);

        for (int i = 0; i < 4; i++) begin
            doReset();
            base = log_addr.size();
            for (int b = 0; b < vecs[i].nbytes; b++)
                applyStimulus(vecs[i].bytes[111-8*b -: 8], !vecs[i].bad[b]);
            repeat (20) @(negedge clk);
            checkOutput($sformatf("v%0d_num_writes", i), 32'(log_addr.size() - base),
                        32'(vecs[i].nwr));
            for (int k = 0; k < vecs[i].nwr; k++) begin
                if (base + k < log_addr.size()) begin
                    checkOutput($sformatf("v%0d_addr%0d", i, k), log_addr[base+k],
                                vecs[i].addrs[63-32*k -: 32]);
                    checkOutput($sformatf("v%0d_data%0d", i, k), log_data[base+k],
                                vecs[i].datas[63-32*k -: 32]);
                end
            end
            checkOutput($sformatf("v%0d_word_count", i), 32'(word_count), 32'(vecs[i].wc));
            checkOutput($sformatf("v%0d_done", i),       32'(done),       32'(vecs[i].dn));
            checkOutput($sformatf("v%0d_cpu_hold", i),   32'(cpu_hold),   32'(!vecs[i].dn));
            checkOutput($sformatf("v%0d_overflow", i),   32'(overflow),   32'(vecs[i].ovf));
            checkOutput($sformatf("v%0d_frame_err", i),  32'(frame_err),  32'(vecs[i].ferr));
            checkOutput($sformatf("v%0d_wr_addr", i),    mem.wr_addr,     vecs[i].final_addr);
            if (vecs[i].lag)
                checkOutput($sformatf("v%0d_hold_lag", i),
                            32'(hold_fall_cyc - last_wr_cyc), 32'd1);
        end

        // Zero-length program: Done must rise during the second header byte's stop bit.
        doReset();
        base = log_addr.size();
        applyStimulus(8'h00, 1'b1);
        frame = {1'b1, 8'h00, 1'b0};
        done_early = 1'b1;
        done_late  = 1'b0;
        for (int c = 0; c < 176; c++) begin
            rx = (c < 160) ? frame[c/CPB] : 1'b1;
            if (c == 144) done_early = done;
            if (c == 160) done_late  = done;
            @(negedge clk);
        end
        checkOutput("zero_done_before_stop", 32'(done_early), 32'd0);
        checkOutput("zero_done_after_stop",  32'(done_late),  32'd1);
        checkOutput("zero_cpu_hold",         32'(cpu_hold),   32'd0);
        checkOutput("zero_num_writes", 32'(log_addr.size() - base), 32'd0);

        // Glitches on the idle line must not produce bytes.
        doReset();
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h01, 1'b1);
        base = log_addr.size();
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        rx = 1'b0;
        repeat (CPB/2) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("glitch_num_writes", 32'(log_addr.size() - base), 32'd0);
        checkOutput("glitch_frame_err",  32'(frame_err),  32'd0);
        checkOutput("glitch_word_count", 32'(word_count), 32'd0);
        applyStimulus(8'h0B, 1'b1);
        applyStimulus(8'hAD, 1'b1);
        applyStimulus(8'hF0, 1'b1);
        applyStimulus(8'h0D, 1'b1);
        repeat (20) @(negedge clk);
        checkOutput("glitch_after_writes", 32'(log_addr.size() - base), 32'd1);
        if (log_data.size() > base)
            checkOutput("glitch_after_data", log_data[base], 32'h0BADF00D);
        checkOutput("glitch_after_done", 32'(done), 32'd1);

        // Reset in the middle of a load, then a fresh load and ignored trailing bytes.
        doReset();
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h02, 1'b1);
        applyStimulus(8'h12, 1'b1);
        applyStimulus(8'h34, 1'b1);
        rx = 1'b0;
        repeat (40) @(negedge clk);
        rx  = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_word_count", 32'(word_count), 32'd0);
        checkOutput("midrst_wr_addr",    mem.wr_addr,     32'h0);
        checkOutput("midrst_cpu_hold",   32'(cpu_hold),   32'd1);
        checkOutput("midrst_done",       32'(done),       32'd0);
        base = log_addr.size();
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'hA1, 1'b1);
        applyStimulus(8'hB2, 1'b1);
        applyStimulus(8'hC3, 1'b1);
        applyStimulus(8'hD4, 1'b1);
        repeat (20) @(negedge clk);
        checkOutput("reload_num_writes", 32'(log_addr.size() - base), 32'd1);
        if (log_addr.size() > base) begin
            checkOutput("reload_addr", log_addr[base], 32'h0);
            checkOutput("reload_data", log_data[base], 32'hA1B2C3D4);
        end
        checkOutput("reload_done", 32'(done), 32'd1);
        applyStimulus(8'h55, 1'b1);
        applyStimulus(8'h66, 1'b1);
        applyStimulus(8'h77, 1'b1);
        applyStimulus(8'h88, 1'b1);
        repeat (20) @(negedge clk);
        checkOutput("after_done_writes",     32'(log_addr.size() - base), 32'd1);
        checkOutput("after_done_word_count", 32'(word_count), 32'd1);

        checkOutput("back_to_back_wr_en", 32'(b2b), 32'd0);
        checkOutput("max_wr_addr",        max_addr, 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
